// File: rtl/fetch_pkg.sv
// Shared widths, constants and the queue entry type for the instruction fetch stage.
package fetch_pkg;

  localparam int INSTR_W  = 14;
  localparam int PC_W     = 13;
  localparam int FQ_DEPTH = 2;
  localparam int CNT_W    = $clog2(FQ_DEPTH + 1);
  localparam int PTR_W    = $clog2(FQ_DEPTH);

  localparam logic [INSTR_W-1:0] NOP_INSTR = 14'h0000;
  localparam logic [CNT_W-1:0]   FQ_FULL   = CNT_W'(FQ_DEPTH);

  // One queued instruction together with the address it was fetched from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction queue of {instr, pc} pairs with push, pop and flush.
// Flush wins over push and pop. Pointers wrap naturally, so FQ_DEPTH must be
// a power of two.
import fetch_pkg::*;

module fetch_fifo (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic [INSTR_W-1:0] push_instr_i,
  input  logic [PC_W-1:0]    push_pc_i,
  input  logic               pop_i,
  output logic [CNT_W-1:0]   count_o,
  output logic [INSTR_W-1:0] head_instr_o,
  output logic [PC_W-1:0]    head_pc_o
);

  fq_entry_t        mem_q [FQ_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s, do_pop_s;

  // Next pointers and occupancy; a push into a full queue is only taken alongside a pop.
  always_comb begin
    do_push_s = push_i && ((count_q != FQ_FULL) || pop_i);
    do_pop_s  = pop_i && (count_q != '0);
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer, count and storage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (do_push_s && !flush_i) begin
        mem_q[wr_ptr_q] <= {push_instr_i, push_pc_i};
      end
    end
  end

  assign count_o      = count_q;
  assign head_instr_o = mem_q[rd_ptr_q].instr;
  assign head_pc_o    = mem_q[rd_ptr_q].pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues word reads from fetch_pc, queues the returned
// words with their addresses and presents the queue head to the decoder.
// Optional feature macro FETCH_SKIP_EN: when defined, a skip pulse turns the
// next instruction handed to the decoder into a NOP.
import fetch_pkg::*;

module fetch_stage (
  input  logic               clk,
  input  logic               reset,
  output logic               mem_en,
  output logic [PC_W-1:0]    mem_addr,
  input  logic [INSTR_W-1:0] mem_data,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               skip,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [PC_W-1:0]    dec_pc
);

  localparam logic [CNT_W:0] OCC_LIMIT = (CNT_W + 1)'(FQ_DEPTH);

  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]    rsp_pc_q, rsp_pc_d;
  logic               inflight_q, inflight_d;
  logic [CNT_W-1:0]   count_s;
  logic [CNT_W:0]     occ_s;
  logic [INSTR_W-1:0] head_instr_s;
  logic [PC_W-1:0]    head_pc_s;
  logic               hs_s, push_s, pop_s;

  assign hs_s  = dec_valid && dec_ready;
  // Slots already spoken for once this cycle's handshake has left the queue.
  assign occ_s = {1'b0, count_s} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, hs_s};
  // The read returning during a redirect belongs to the old stream and is dropped.
  assign push_s = inflight_q && !redirect;
  assign pop_s  = hs_s && !redirect;

  // Read issue and fetch address update; mem_en is held low while redirecting.
  always_comb begin
    mem_en     = 1'b0;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    if (reset || redirect) begin
      mem_en = 1'b0;
    end else if (occ_s < OCC_LIMIT) begin
      mem_en = 1'b1;
    end else begin
      mem_en = 1'b0;
    end
    if (redirect) begin
      fetch_pc_d = redirect_pc;
    end else if (mem_en) begin
      fetch_pc_d = fetch_pc_q + 1'b1;
      rsp_pc_d   = fetch_pc_q;
    end else begin
      fetch_pc_d = fetch_pc_q;
    end
    inflight_d = mem_en;
  end

  // Fetch address, in-flight flag and address of the read currently returning.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= '0;
      rsp_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo u_fifo (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (redirect),
    .push_i       (push_s),
    .push_instr_i (mem_data),
    .push_pc_i    (rsp_pc_q),
    .pop_i        (pop_s),
    .count_o      (count_s),
    .head_instr_o (head_instr_s),
    .head_pc_o    (head_pc_s)
  );

  assign mem_addr  = fetch_pc_q;
  assign dec_valid = (count_s != '0);
  assign dec_pc    = head_pc_s;

`ifdef FETCH_SKIP_EN
  logic skip_pending_q, skip_pending_d;

  // A skip arms the squash for the next entry handed over; redirect disarms it.
  always_comb begin
    skip_pending_d = skip_pending_q;
    if (redirect) begin
      skip_pending_d = 1'b0;
    end else if (skip) begin
      skip_pending_d = 1'b1;
    end else if (hs_s) begin
      skip_pending_d = 1'b0;
    end else begin
      skip_pending_d = skip_pending_q;
    end
  end

  // Squash-pending register.
  always_ff @(posedge clk) begin
    if (reset) begin
      skip_pending_q <= 1'b0;
    end else begin
      skip_pending_q <= skip_pending_d;
    end
  end

  assign dec_instr = skip_pending_q ? NOP_INSTR : head_instr_s;
`else
  logic unused_skip_s;
  assign unused_skip_s = skip;
  assign dec_instr     = head_instr_s;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios followed by random traffic,
// checked by a scoreboard of expected {pc, instr} deliveries.
module tb_fetch_stage;

`ifdef FETCH_SKIP_EN
  localparam bit SKIP_ON = 1'b1;
`else
  localparam bit SKIP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_en;
  logic [12:0] mem_addr;
  logic [13:0] mem_data = 14'h3FFF;
  logic        redirect = 1'b0;
  logic [12:0] redirect_pc = 13'h0;
  logic        skip = 1'b0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [13:0] dec_instr;
  logic [12:0] dec_pc;

  int n_chk  = 0;
  int n_pass = 0;

  logic [12:0] exp_q[$];
  logic [12:0] next_pc_m = 13'h0;

  fetch_stage u_dut (
    .clk         (clk),
    .reset       (reset),
    .mem_en      (mem_en),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .skip        (skip),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_instr   (dec_instr),
    .dec_pc      (dec_pc)
  );

  always #5 clk = ~clk;

  // Contents of instruction memory: never zero, so a NOP is always distinguishable.
  function automatic logic [13:0] mem_word(input logic [12:0] a);
    return {1'b1, a} ^ 14'h0A5A;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // Memory: a request seen in one cycle is answered during the next cycle.
  logic        rq_en = 1'b0;
  logic [12:0] rq_addr = 13'h0;
  always @(negedge clk) begin
    rq_en   = mem_en;
    rq_addr = mem_addr;
  end
  always @(posedge clk) begin
    #1;
    mem_data = rq_en ? mem_word(rq_addr) : 14'h3FFF;
  end

  // One cycle of stimulus; restarts the expected stream on reset/redirect.
  task automatic cyc(input logic rdy, input logic rdr, input logic [12:0] rpc,
                     input logic skp, input logic rst);
    @(posedge clk);
    #1;
    dec_ready   = rdy;
    redirect    = rdr;
    redirect_pc = rpc;
    skip        = skp;
    reset       = rst;
    if (rst) begin
      exp_q.delete();
      next_pc_m = 13'h0;
    end else if (rdr) begin
      exp_q.delete();
      next_pc_m = rpc;
    end
    while (exp_q.size() < 4) begin
      exp_q.push_back(next_pc_m);
      next_pc_m = next_pc_m + 13'h1;
    end
    #1;
  endtask

  // Scoreboard monitor: every handshake pops the next expected delivery.
  logic        pend_m = 1'b0;
  int          idle_cnt = 0;
  logic [12:0] epc;
  logic [13:0] einstr;
  always @(negedge clk) begin
    if (reset || redirect) begin
      pend_m   = 1'b0;
      idle_cnt = 0;
    end else begin
      if (dec_valid && dec_ready) begin
        idle_cnt = 0;
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_delivery", int'(dec_pc), -1);
        end else begin
          epc    = exp_q.pop_front();
          einstr = pend_m ? 14'h0000 : mem_word(epc);
          chk("sb_pc", int'(dec_pc), int'(epc));
          chk("sb_instr", int'(dec_instr), int'(einstr));
          pend_m = 1'b0;
        end
      end else if (dec_ready) begin
        idle_cnt++;
        if (idle_cnt == 8) chk("watchdog_idle_cycles", idle_cnt, 0);
      end
      if (skip && SKIP_ON) pend_m = 1'b1;
    end
  end

  int v;
  int found;
  logic        r_rst, r_rdr;
  logic [12:0] r_pc;

  initial begin
    // Reset state
    repeat (3) cyc(1'b0, 1'b0, 13'h0, 1'b0, 1'b1);
    chk("rst_mem_en", int'(mem_en), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_dec_valid", int'(dec_valid), 0);
    chk("rst_dec_pc", int'(dec_pc), 0);
    chk("rst_dec_instr", int'(dec_instr), 0);

    // Reset release with steady flow
    cyc(1'b1, 1'b0, 13'h0, 1'b0, 1'b0);
    chk("first_mem_en", int'(mem_en), 1);
    chk("first_mem_addr", int'(mem_addr), 0);
    chk("first_dec_valid", int'(dec_valid), 0);
    cyc(1'b1, 1'b0, 13'h0, 1'b0, 1'b0);
    chk("second_mem_addr", int'(mem_addr), 1);
    chk("second_dec_valid", int'(dec_valid), 0);
    cyc(1'b1, 1'b0, 13'h0, 1'b0, 1'b0);
    chk("latency_dec_valid", int'(dec_valid), 1);
    chk("latency_dec_pc", int'(dec_pc), 0);
    v = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0, 13'h0, 1'b0, 1'b0);
      v += int'(dec_valid);
    end
    chk("throughput", v, 20);

    // Backpressure for 5 cycles
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 13'h0, 1'b0, 1'b0);
      chk("bp_head_pc", int'(dec_pc), int'(exp_q[0]));
      chk("bp_head_instr", int'(dec_instr), int'(mem_word(exp_q[0])));
    end
    chk("bp_mem_en", int'(mem_en), 0);
    chk("bp_count", int'(u_dut.u_fifo.count_o), 2);
    repeat (10) cyc(1'b1, 1'b0, 13'h0, 1'b0, 1'b0);

    // Redirect with a read in flight
    chk("pre_redirect_mem_en", int'(mem_en), 1);
    cyc(1'b1, 1'b1, 13'h0123, 1'b0, 1'b0);
    chk("redir_mem_en", int'(mem_en), 0);
    cyc(1'b1, 1'b0, 13'h0, 1'b0, 1'b0);
    chk("redir_t1_mem_addr", int'(mem_addr), 'h123);
    chk("redir_t1_mem_en", int'(mem_en), 1);
    chk("redir_t1_dec_valid", int'(dec_valid), 0);
    cyc(1'b1, 1'b0, 13'h0, 1'b0, 1'b0);
    chk("redir_t2_dec_valid", int'(dec_valid), 0);
    cyc(1'b1, 1'b0, 13'h0, 1'b0, 1'b0);
    chk("redir_t3_dec_valid", int'(dec_valid), 1);
    chk("redir_t3_dec_pc", int'(dec_pc), 'h123);
    chk("redir_t3_dec_instr", int'(dec_instr), int'(mem_word(13'h0123)));

    // Skip while pc=5 is handshaken
    repeat (2) cyc(1'b1, 1'b0, 13'h0, 1'b0, 1'b1);
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      cyc(1'b1, 1'b0, 13'h0, 1'b0, 1'b0);
      if (dec_valid && dec_pc == 13'd4) found = 1;
    end
    chk("skip_reach_pc4", found, 1);
    cyc(1'b1, 1'b0, 13'h0, 1'b1, 1'b0);
    chk("skip_pc5_pc", int'(dec_pc), 5);
    chk("skip_pc5_instr", int'(dec_instr), int'(mem_word(13'd5)));
    cyc(1'b1, 1'b0, 13'h0, 1'b0, 1'b0);
    chk("skip_pc6_pc", int'(dec_pc), 6);
    chk("skip_pc6_instr", int'(dec_instr), SKIP_ON ? 0 : int'(mem_word(13'd6)));
    cyc(1'b1, 1'b0, 13'h0, 1'b0, 1'b0);
    chk("skip_pc7_pc", int'(dec_pc), 7);
    chk("skip_pc7_instr", int'(dec_instr), int'(mem_word(13'd7)));

    // Address wrap 8190, 8191, 0, 1
    cyc(1'b1, 1'b1, 13'd8190, 1'b0, 1'b0);
    repeat (2) cyc(1'b1, 1'b0, 13'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 13'h0, 1'b0, 1'b0);
      chk("wrap_dec_valid", int'(dec_valid), 1);
      chk("wrap_dec_pc", int'(dec_pc), (8190 + i) % 8192);
    end

    // Skip and redirect together
    cyc(1'b1, 1'b1, 13'h0200, 1'b1, 1'b0);
    repeat (2) cyc(1'b1, 1'b0, 13'h0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 13'h0, 1'b0, 1'b0);
    chk("skip_redir_dec_pc", int'(dec_pc), 'h200);
    chk("skip_redir_dec_instr", int'(dec_instr), int'(mem_word(13'h0200)));

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 299) == 0);
      r_rdr = ($urandom_range(0, 19) == 0);
      r_pc  = ($urandom_range(0, 3) == 0) ? 13'(8188 + $urandom_range(0, 3)) : 13'($urandom);
      cyc($urandom_range(0, 3) != 0, r_rdr, r_pc, $urandom_range(0, 7) == 0, r_rst);
    end
    repeat (5) cyc(1'b1, 1'b0, 13'h0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
